// File: rtl/yachip8_pkg.sv
// Shared definitions for the yachip8 RAM arbitration logic.
package yachip8_pkg;

    // Owner of the shared RAM for the current cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_HOST = 2'd1,
        OWN_CPU  = 2'd2,
        OWN_DISP = 2'd3
    } owner_e;

    // Byte address widths of the two RAM instances.
    localparam int CH_ADDR_W   = 12;
    localparam int DISP_ADDR_W = 8;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the dual-port RAM.
// slave: the arbiter side; master: requesters plus RAM.
interface ram_arbiter_if #(
    parameter int ADDR_W = 12
);
    logic              host_valid;
    logic              host_ready;
    logic [ADDR_W-2:0] host_addr;
    logic [15:0]       host_wdata;

    logic              cpu_req;
    logic              cpu_gnt;
    logic [ADDR_W-1:0] cpu_aa;
    logic [ADDR_W-1:0] cpu_ab;
    logic [7:0]        cpu_da;
    logic [7:0]        cpu_db;
    logic              cpu_wa;
    logic              cpu_wb;

    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_gnt;
    logic              disp_rvalid;
    logic [7:0]        disp_rdata;

    logic [ADDR_W-1:0] ram_aa;
    logic [ADDR_W-1:0] ram_ab;
    logic [7:0]        ram_da;
    logic [7:0]        ram_db;
    logic              ram_wa;
    logic              ram_wb;
    logic [7:0]        ram_qa;

    logic [15:0]       stat_stall;

    modport slave (
        input  host_valid, host_addr, host_wdata,
        input  cpu_req, cpu_aa, cpu_ab, cpu_da, cpu_db, cpu_wa, cpu_wb,
        input  disp_req, disp_addr, ram_qa,
        output host_ready, cpu_gnt, disp_gnt, disp_rvalid, disp_rdata,
        output ram_aa, ram_ab, ram_da, ram_db, ram_wa, ram_wb, stat_stall
    );

    modport master (
        output host_valid, host_addr, host_wdata,
        output cpu_req, cpu_aa, cpu_ab, cpu_da, cpu_db, cpu_wa, cpu_wb,
        output disp_req, disp_addr, ram_qa,
        input  host_ready, cpu_gnt, disp_gnt, disp_rvalid, disp_rdata,
        input  ram_aa, ram_ab, ram_da, ram_db, ram_wa, ram_wb, stat_stall
    );
endinterface

// File: rtl/ram_arbiter_host_wr_buf.sv
// One-entry valid/ready buffer holding a host 16-bit word write until the
// arbiter grants it the RAM. Accept and drain are mutually exclusive since
// accept needs the buffer empty and drain needs it full.
module host_wr_buf #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-2:0] in_addr,
    input  logic [15:0]       in_data,
    input  logic              drain,
    output logic              full,
    output logic [ADDR_W-2:0] addr,
    output logic [15:0]       data
);
    logic              full_q, full_d;
    logic [ADDR_W-2:0] addr_q, addr_d;
    logic [15:0]       data_q, data_d;

    assign in_ready = !full_q;
    assign full     = full_q;
    assign addr     = addr_q;
    assign data     = data_q;

    // Next-state: capture a word when empty, release it on drain.
    always_comb begin
        full_d = full_q;
        addr_d = addr_q;
        data_d = data_q;
        if (drain) begin
            full_d = 1'b0;
        end else if (in_valid && !full_q) begin
            full_d = 1'b1;
            addr_d = in_addr;
            data_d = in_data;
        end
    end

    // State registers; reset drops any buffered word.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end
endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates one dual-port byte RAM between host word writes (buffered),
// the CPU core and display scan-out reads. A display starved for
// DISP_MAX_WAIT consecutive cycles is promoted above everything else.
// Optional macro ARB_STATS_EN builds the stat_stall counter.
module ram_arbiter
    import yachip8_pkg::*;
#(
    parameter int ADDR_W        = CH_ADDR_W,
    parameter int DISP_MAX_WAIT = 4,
    parameter int WAIT_W        = 3
) (
    input  logic clk,
    input  logic reset,
    ram_arbiter_if.slave bus
);
    localparam logic [WAIT_W-1:0] WAIT_MAX = '1;
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(DISP_MAX_WAIT);

    owner_e            owner;
    logic              buf_full;
    logic [ADDR_W-2:0] buf_addr;
    logic [15:0]       buf_data;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              disp_rvalid_q, disp_rvalid_d;
    logic              disp_denied;

    host_wr_buf #(.ADDR_W(ADDR_W)) u_host_wr_buf (
        .clk      (clk),
        .reset    (reset),
        .in_valid (bus.host_valid),
        .in_ready (bus.host_ready),
        .in_addr  (bus.host_addr),
        .in_data  (bus.host_wdata),
        .drain    (owner == OWN_HOST),
        .full     (buf_full),
        .addr     (buf_addr),
        .data     (buf_data)
    );

    // Owner select; nobody owns the RAM while reset is asserted.
    always_comb begin
        owner = OWN_NONE;
        if (!reset) begin
            if (bus.disp_req && wait_cnt_q >= WAIT_LIM) owner = OWN_DISP;
            else if (buf_full)                          owner = OWN_HOST;
            else if (bus.cpu_req)                       owner = OWN_CPU;
            else if (bus.disp_req)                      owner = OWN_DISP;
        end
    end

    assign bus.cpu_gnt     = (owner == OWN_CPU);
    assign bus.disp_gnt    = (owner == OWN_DISP);
    assign bus.disp_rvalid = disp_rvalid_q;
    assign bus.disp_rdata  = bus.ram_qa;
    assign disp_denied     = bus.disp_req && (owner != OWN_DISP);

    // RAM port mux driven by the current owner; idle ports are all-zero.
    always_comb begin
        bus.ram_aa = '0;
        bus.ram_ab = '0;
        bus.ram_da = '0;
        bus.ram_db = '0;
        bus.ram_wa = 1'b0;
        bus.ram_wb = 1'b0;
        case (owner)
            OWN_HOST: begin
                bus.ram_aa = {buf_addr, 1'b0};
                bus.ram_da = buf_data[15:8];
                bus.ram_ab = {buf_addr, 1'b1};
                bus.ram_db = buf_data[7:0];
                bus.ram_wa = 1'b1;
                bus.ram_wb = 1'b1;
            end
            OWN_CPU: begin
                bus.ram_aa = bus.cpu_aa;
                bus.ram_ab = bus.cpu_ab;
                bus.ram_da = bus.cpu_da;
                bus.ram_db = bus.cpu_db;
                bus.ram_wa = bus.cpu_wa;
                bus.ram_wb = bus.cpu_wb;
            end
            OWN_DISP: begin
                bus.ram_aa = bus.disp_addr;
            end
            default: ;
        endcase
    end

    // Wait counter: counts consecutive denied display cycles, saturating.
    always_comb begin
        wait_cnt_d    = '0;
        disp_rvalid_d = (owner == OWN_DISP);
        if (disp_denied) begin
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end
    end

    // Wait counter and read-valid registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q    <= '0;
            disp_rvalid_q <= 1'b0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            disp_rvalid_q <= disp_rvalid_d;
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] stall_q, stall_d;

    // Saturating count of every denied display cycle.
    always_comb begin
        stall_d = stall_q;
        if (disp_denied && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (reset) stall_q <= '0;
        else       stall_q <= stall_d;
    end

    assign bus.stat_stall = stall_q;
`else
    assign bus.stat_stall = '0;
`endif
endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: the driver applies stimulus, predicts
// the cycle's outputs with a behavioural model and queues them; the monitor
// compares on the falling edge.
module tb_ram_arbiter;
    localparam int AW = 12;
    localparam int MAXW = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ram_arbiter_if #(.ADDR_W(AW)) bus ();

    ram_arbiter #(.ADDR_W(AW), .DISP_MAX_WAIT(MAXW), .WAIT_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Environment RAM: read-first, one-cycle read latency on port A.
    logic [7:0] env_mem [0:4095];
    always @(posedge clk) begin
        bus.ram_qa <= env_mem[bus.ram_aa];
        if (bus.ram_wa) env_mem[bus.ram_aa] <= bus.ram_da;
        if (bus.ram_wb) env_mem[bus.ram_ab] <= bus.ram_db;
    end

    typedef struct {
        int         cyc;
        int         own;
        bit         host_ready, cpu_gnt, disp_gnt, rvalid;
        logic [7:0] rdata;
        logic [11:0] aa, ab;
        logic [7:0] da, db;
        bit         wa, wb;
        logic [15:0] stall;
    } exp_t;

    exp_t sb[$];
    int n_err = 0;
    int n_checks = 0;
    int cyc = 0;

    // Stimulus values for the next cycle.
    bit v_rst, v_hv, v_cr, v_cwa, v_cwb, v_dr;
    logic [10:0] v_ha;
    logic [15:0] v_hd;
    logic [11:0] v_caa, v_cab, v_dad;
    logic [7:0] v_cda, v_cdb;

    // Reference model state.
    logic [7:0] m_mem [0:4095];
    bit m_full = 0;
    logic [10:0] m_baddr;
    logic [15:0] m_bdata;
    int m_streak = 0;
    bit m_prev_dg = 0;
    logic [7:0] m_rd;
    int m_stall = 0;
    int m_last_own = 0;

    task automatic chk(string nm, int c, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, c, act, exp);
        end
    endtask

    // One cycle: drive inputs, predict outputs, advance the model.
    task automatic step();
        exp_t e;
        int own;
        @(posedge clk);
        #1;
        reset          = v_rst;
        bus.host_valid = v_hv;  bus.host_addr = v_ha;  bus.host_wdata = v_hd;
        bus.cpu_req    = v_cr;  bus.cpu_aa = v_caa;    bus.cpu_ab = v_cab;
        bus.cpu_da     = v_cda; bus.cpu_db = v_cdb;    bus.cpu_wa = v_cwa; bus.cpu_wb = v_cwb;
        bus.disp_req   = v_dr;  bus.disp_addr = v_dad;

        own = 0;
        if (!v_rst) begin
            if (v_dr && m_streak >= MAXW) own = 3;
            else if (m_full)              own = 1;
            else if (v_cr)                own = 2;
            else if (v_dr)                own = 3;
        end
        e.cyc = cyc; e.own = own;
        e.host_ready = !m_full;
        e.cpu_gnt = (own == 2);
        e.disp_gnt = (own == 3);
        e.rvalid = m_prev_dg;
        e.rdata = m_rd;
        e.aa = '0; e.ab = '0; e.da = '0; e.db = '0; e.wa = 0; e.wb = 0;
        if (own == 1) begin
            e.aa = {m_baddr, 1'b0}; e.da = m_bdata[15:8];
            e.ab = {m_baddr, 1'b1}; e.db = m_bdata[7:0];
            e.wa = 1; e.wb = 1;
        end else if (own == 2) begin
            e.aa = v_caa; e.ab = v_cab; e.da = v_cda; e.db = v_cdb; e.wa = v_cwa; e.wb = v_cwb;
        end else if (own == 3) begin
            e.aa = v_dad;
        end
`ifdef ARB_STATS_EN
        e.stall = 16'(m_stall);
`else
        e.stall = 16'h0;
`endif
        sb.push_back(e);

        if (own == 3) m_rd = m_mem[v_dad];
        if (e.wa) m_mem[e.aa] = e.da;
        if (e.wb) m_mem[e.ab] = e.db;
        if (v_rst) begin
            m_full = 0; m_streak = 0; m_prev_dg = 0; m_stall = 0;
        end else begin
            if (own == 1) m_full = 0;
            else if (v_hv && !m_full) begin
                m_full = 1; m_baddr = v_ha; m_bdata = v_hd;
            end
            if (v_dr && own != 3) begin
                m_streak++;
                if (m_stall < 65535) m_stall++;
            end else begin
                m_streak = 0;
            end
            m_prev_dg = (own == 3);
        end
        m_last_own = own;
        cyc++;
    endtask

    task automatic idle();
        v_rst = 0; v_hv = 0; v_cr = 0; v_dr = 0;
        v_cwa = 0; v_cwb = 0;
    endtask

    // Monitor: compare every queued expectation against the live outputs.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("host_ready", e.cyc, 32'(bus.host_ready), 32'(e.host_ready));
            chk("cpu_gnt", e.cyc, 32'(bus.cpu_gnt), 32'(e.cpu_gnt));
            chk("disp_gnt", e.cyc, 32'(bus.disp_gnt), 32'(e.disp_gnt));
            chk("disp_rvalid", e.cyc, 32'(bus.disp_rvalid), 32'(e.rvalid));
            if (e.rvalid) chk("disp_rdata", e.cyc, 32'(bus.disp_rdata), 32'(e.rdata));
            chk("ram_aa", e.cyc, 32'(bus.ram_aa), 32'(e.aa));
            chk("ram_ab", e.cyc, 32'(bus.ram_ab), 32'(e.ab));
            chk("ram_da", e.cyc, 32'(bus.ram_da), 32'(e.da));
            chk("ram_db", e.cyc, 32'(bus.ram_db), 32'(e.db));
            chk("ram_wa", e.cyc, 32'(bus.ram_wa), 32'(e.wa));
            chk("ram_wb", e.cyc, 32'(bus.ram_wb), 32'(e.wb));
            chk("stat_stall", e.cyc, 32'(bus.stat_stall), 32'(e.stall));
            $display("cyc=%0d own=%0d aa=%03h da=%02h ab=%03h db=%02h wa=%0b wb=%0b rv=%0b rd=%02h stall=%0d",
                     e.cyc, e.own, bus.ram_aa, bus.ram_da, bus.ram_ab, bus.ram_db,
                     bus.ram_wa, bus.ram_wb, bus.disp_rvalid, bus.disp_rdata, bus.stat_stall);
        end
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin
            env_mem[i] = 8'h00;
            m_mem[i] = 8'h00;
        end
        bus.ram_qa = 8'h00;
        idle();
        v_ha = '0; v_hd = '0; v_caa = '0; v_cab = '0; v_cda = '0; v_cdb = '0; v_dad = '0;
        reset = 1'b1;
        bus.host_valid = 0; bus.host_addr = '0; bus.host_wdata = '0;
        bus.cpu_req = 0; bus.cpu_aa = '0; bus.cpu_ab = '0; bus.cpu_da = '0; bus.cpu_db = '0;
        bus.cpu_wa = 0; bus.cpu_wb = 0; bus.disp_req = 0; bus.disp_addr = '0;

        // Reset cycles.
        v_rst = 1; step(); step();
        idle(); step();

        // Host word write while idle.
        v_hv = 1; v_ha = 11'h100; v_hd = 16'hA2F0; step();
        idle(); step(); step();

        // CPU and display contending for six cycles.
        v_cr = 1; v_dr = 1; v_caa = 12'h020; v_cab = 12'h021; v_cda = 8'h11; v_cdb = 8'h22;
        repeat (6) step();
        idle(); step();

        // Host, CPU and display all at once; second host write during drain.
        v_hv = 1; v_ha = 11'h055; v_hd = 16'h1234; v_cr = 1; v_dr = 1;
        v_caa = 12'h300; v_cab = 12'h301; v_cwa = 1; v_cda = 8'h5A;
        step();
        v_hd = 16'h9999; step();
        v_hv = 0; repeat (3) step();
        idle(); step();

        // Preload 0x10 with 3C, then read it through the display path.
        v_cr = 1; v_caa = 12'h010; v_cab = 12'h011; v_cda = 8'h3C; v_cwa = 1; step();
        idle(); v_dr = 1; v_dad = 12'h010; step();
        idle(); step(); step();

        // Reset with buffer full and wait count 3.
        v_cr = 1; v_dr = 1; v_caa = 12'h040; v_cab = 12'h041; v_cwa = 0;
        step(); step();
        v_hv = 1; v_ha = 11'h3AA; v_hd = 16'hBEEF; step();
        v_hv = 0; v_rst = 1; step();
        idle(); step(); step();

        // Denied display for stall counting.
        v_cr = 1; v_dr = 1; repeat (6) step();
        idle(); step();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            v_rst = ($urandom_range(0, 79) == 0);
            v_hv = ($urandom_range(0, 3) == 0);
            v_ha = 11'($urandom);
            v_hd = 16'($urandom);
            if (!(v_cr && m_last_own != 2)) begin
                v_cr = ($urandom_range(0, 1) == 1);
                v_caa = 12'($urandom);
                v_cab = v_caa ^ 12'h001;
                v_cda = 8'($urandom);
                v_cdb = 8'($urandom);
                v_cwa = ($urandom_range(0, 1) == 1);
                v_cwb = ($urandom_range(0, 1) == 1);
            end
            v_dr = ($urandom_range(0, 2) != 0);
            v_dad = 12'($urandom);
            step();
        end
        idle(); step(); step();

        @(negedge clk);
        #1;
        chk("scoreboard_drained", cyc, 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
